instr_fetch_unit: RTL and testbench

//  Upstream neighbour of the instruction decode/control stage: owns the PC, issues word fetches to

---
 rtl/instr_fetch_unit.sv | 109 ++++++++++
 tb/tb_instr_fetch_unit.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-outstanding word fetches to instruction
// memory and holds one registered instruction/PC pair for decode, with redirect squashing.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   input  logic        pc_src,
   input  logic [31:0] pc_target
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_fetch_pc;
   logic [31:0] r_inst;
   logic [31:0] r_pc;
   logic        r_inst_valid;

   logic        w_space;
   logic        w_req_hs;
   logic        w_load;
   logic        w_consume;
   logic [31:0] w_target;
   logic [31:0] w_fetch_pc_inc;
   logic        w_unused_tgt;

   assign w_target       = {pc_target[31:2], 2'b00};
   assign w_unused_tgt   = &{1'b0, pc_target[1:0]};
   assign w_fetch_pc_inc = r_fetch_pc + 32'd4;

   assign imem_addr  = r_fetch_pc;
   assign inst_valid = r_inst_valid;
   assign inst_o     = r_inst;
   assign pc_o       = r_pc;

   always_comb begin
      w_space        = ~r_inst_valid | inst_ready;
      imem_req_valid = (r_state == S_REQ) & w_space & ~pc_src & ~rst;
      w_req_hs       = imem_req_valid & imem_req_ready;
      w_load         = (r_state == S_WAIT) & imem_rsp_valid & ~pc_src;
      w_consume      = r_inst_valid & inst_ready;
   end

   // A redirect while waiting leaves the old response in flight; S_DROP swallows it.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_REQ: begin
            if (w_req_hs) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rsp_valid) w_state_nxt = S_REQ;
            else if (pc_src)    w_state_nxt = S_DROP;
         end
         S_DROP: begin
            if (imem_rsp_valid) w_state_nxt = S_REQ;
         end
         default: w_state_nxt = S_REQ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_REQ;
         r_fetch_pc <= RESET_PC_ALIGNED;
      end else begin
         r_state <= w_state_nxt;
         if (pc_src)      r_fetch_pc <= w_target;
         else if (w_load) r_fetch_pc <= w_fetch_pc_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_inst_valid <= 1'b0;
         r_inst       <= NOP_INST;
         r_pc         <= RESET_PC_ALIGNED;
      end else if (pc_src) begin
         r_inst_valid <= 1'b0;
         r_inst       <= NOP_INST;
      end else if (w_load) begin
         r_inst_valid <= 1'b1;
         r_inst       <= imem_rsp_data;
         r_pc         <= r_fetch_pc;
      end else if (w_consume) begin
         r_inst_valid <= 1'b0;
         r_inst       <= NOP_INST;
      end
   end

   // Memory must never answer when no request is outstanding.
   a_no_rsp_in_req: assert property (@(posedge clk) disable iff (rst)
      !(r_state == S_REQ && imem_rsp_valid));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: scoreboard of fetched words plus directed scenarios
// for latency, streaming, backpressure, redirects, PC wrap and asynchronous reset.
module tb_instr_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        pc_src;
   logic [31:0] pc_target;

   logic        d2_req_valid;
   logic [31:0] d2_addr;
   logic        rsp2_valid;
   logic [31:0] rsp2_data;
   logic        d2_inst_valid;
   logic [31:0] d2_inst;
   logic [31:0] d2_pc;

   int          n_checks;
   int          n_fail;
   int          mem_delay;

   logic [63:0] sb[$];
   logic [31:0] exp2_addr[$];
   logic [31:0] exp2_pc[$];

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_o(inst_o), .pc_o(pc_o),
      .pc_src(pc_src), .pc_target(pc_target)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut_wrap (
      .clk(clk), .rst(rst),
      .imem_req_valid(d2_req_valid), .imem_req_ready(1'b1), .imem_addr(d2_addr),
      .imem_rsp_valid(rsp2_valid), .imem_rsp_data(rsp2_data),
      .inst_valid(d2_inst_valid), .inst_ready(1'b1), .inst_o(d2_inst), .pc_o(d2_pc),
      .pc_src(1'b0), .pc_target(32'h0000_0000)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time expired, required completion");
      $fatal(1, "watchdog");
   end

   // Memory model for dut plus scoreboard push (on request) / pop (on consume).
   initial begin
      logic        pend;
      logic [31:0] paddr;
      int          cnt;
      logic [63:0] exp;
      pend = 1'b0; paddr = '0; cnt = 0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      forever begin
         @(posedge clk);
         if (rst) begin
            pend = 1'b0;
            sb.delete();
         end else begin
            if (imem_rsp_valid) pend = 1'b0;
            if (pc_src) sb.delete();
            else if (inst_valid && inst_ready) begin
               n_checks++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL sb_unexpected: got pc_o=%h inst_o=%h, expected no valid instruction", pc_o, inst_o);
               end else begin
                  exp = sb.pop_front();
                  if ({pc_o, inst_o} !== exp) begin
                     n_fail++;
                     $display("FAIL sb_data: got pc=%h inst=%h, expected pc=%h inst=%h", pc_o, inst_o, exp[63:32], exp[31:0]);
                  end
               end
            end
            if (imem_req_valid && imem_req_ready) begin
               n_checks++;
               if (pend || imem_addr[1:0] !== 2'b00) begin
                  n_fail++;
                  $display("FAIL sb_request: got outstanding=%b addr=%h, expected none outstanding and aligned", pend, imem_addr);
               end
               pend  = 1'b1;
               paddr = imem_addr;
               cnt   = mem_delay;
               sb.push_back({imem_addr, mem_word(imem_addr)});
            end
         end
         #1;
         if (pend && cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(paddr);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
            if (pend) cnt--;
         end
      end
   end

   // Zero-wait, always-ready memory for the wrap instance.
   initial begin
      logic        hs2;
      logic [31:0] a2;
      rsp2_valid = 1'b0;
      rsp2_data  = '0;
      forever begin
         @(posedge clk);
         hs2 = d2_req_valid && !rst;
         a2  = d2_addr;
         #1;
         rsp2_valid = hs2;
         rsp2_data  = mem_word(a2);
      end
   end

   task automatic test_reset;
      rst = 1'b1;
      #1;
      n_checks++;
      if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", inst_valid); end
      n_checks++;
      if (inst_o !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h, expected %h", inst_o, NOP); end
      n_checks++;
      if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h, expected 0", pc_o); end
      n_checks++;
      if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b, expected 0", imem_req_valid); end
      n_checks++;
      if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h, expected 0", imem_addr); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_first_fetch;
      #1;
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
         n_fail++; $display("FAIL first_req: got valid=%b addr=%h, expected 1 and 0", imem_req_valid, imem_addr);
      end
      @(negedge clk); #1;
      n_checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
         n_fail++; $display("FAIL first_wait: got req=%b valid=%b, expected 0 and 0", imem_req_valid, inst_valid);
      end
      @(negedge clk); #1;
      n_checks++;
      if (inst_valid !== 1'b1 || pc_o !== 32'h0 || inst_o !== mem_word(32'h0)) begin
         n_fail++; $display("FAIL first_inst: got valid=%b pc=%h inst=%h, expected 1 0 %h", inst_valid, pc_o, inst_o, mem_word(32'h0));
      end
   endtask

   task automatic test_stream;
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk); #1;
         n_checks++;
         if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL stream_gap: got valid=%b, expected 0", inst_valid); end
         @(negedge clk); #1;
         n_checks++;
         if (inst_valid !== 1'b1 || pc_o !== 32'(4 * i) || inst_o !== mem_word(32'(4 * i))) begin
            n_fail++; $display("FAIL stream_inst: got valid=%b pc=%h inst=%h, expected pc=%h", inst_valid, pc_o, inst_o, 32'(4 * i));
         end
      end
   endtask

   task automatic test_backpressure;
      inst_ready = 1'b0;
      #1;
      n_checks++;
      if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req: got %b, expected 0", imem_req_valid); end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         n_checks++;
         if (inst_valid !== 1'b1 || pc_o !== 32'h8 || inst_o !== mem_word(32'h8) || imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold: got valid=%b pc=%h inst=%h req=%b, expected 1 8 %h 0", inst_valid, pc_o, inst_o, imem_req_valid, mem_word(32'h8));
         end
      end
      inst_ready = 1'b1;
      mem_delay  = 3;
      #1;
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'hC) begin
         n_fail++; $display("FAIL bp_release: got req=%b addr=%h, expected 1 c", imem_req_valid, imem_addr);
      end
   endtask

   task automatic test_redirect;
      bit found;
      // The 0xC fetch now issues with a 3-cycle response delay; next request is to 0x10.
      @(negedge clk); #1;
      @(negedge clk); #1;
      n_checks++;
      if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
         n_fail++; $display("FAIL redir_pre: got valid=%b req=%b, expected 0 0", inst_valid, imem_req_valid);
      end
      @(negedge clk); #1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      n_checks++;
      if (inst_valid !== 1'b1 || pc_o !== 32'hC) begin
         n_fail++; $display("FAIL redir_c: got valid=%b pc=%h, expected 1 c", inst_valid, pc_o);
      end
      @(negedge clk);
      pc_src    = 1'b1;
      pc_target = 32'h0000_0102;
      mem_delay = 0;
      #1;
      n_checks++;
      if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_req: got %b, expected 0", imem_req_valid); end
      @(negedge clk);
      pc_src = 1'b0;
      #1;
      n_checks++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
         n_fail++; $display("FAIL redir_drop: got req=%b valid=%b, expected 0 0", imem_req_valid, inst_valid);
      end
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk); #1;
         n_checks++;
         if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stale: got valid=%b pc=%h, expected 0", inst_valid, pc_o); end
         if (imem_req_valid) found = 1'b1;
      end
      n_checks++;
      if (!found || imem_addr !== 32'h100) begin
         n_fail++; $display("FAIL redir_addr: got found=%b addr=%h, expected 1 100", found, imem_addr);
      end
      @(negedge clk); #1;
      @(negedge clk); #1;
      n_checks++;
      if (inst_valid !== 1'b1 || pc_o !== 32'h100 || inst_o !== mem_word(32'h100)) begin
         n_fail++; $display("FAIL redir_inst: got valid=%b pc=%h inst=%h, expected 1 100 %h", inst_valid, pc_o, inst_o, mem_word(32'h100));
      end
   endtask

   task automatic test_redirect_rsp_same;
      @(negedge clk);
      pc_src    = 1'b1;
      pc_target = 32'h0000_0203;
      #1;
      n_checks++;
      if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rsame_req: got %b, expected 0", imem_req_valid); end
      @(negedge clk);
      pc_src = 1'b0;
      #1;
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200 || inst_valid !== 1'b0) begin
         n_fail++; $display("FAIL rsame_state: got req=%b addr=%h valid=%b, expected 1 200 0", imem_req_valid, imem_addr, inst_valid);
      end
      @(negedge clk); #1;
      @(negedge clk); #1;
      n_checks++;
      if (inst_valid !== 1'b1 || pc_o !== 32'h200) begin
         n_fail++; $display("FAIL rsame_inst: got valid=%b pc=%h, expected 1 200", inst_valid, pc_o);
      end
   endtask

   task automatic test_reset_mid_wait;
      mem_delay = 3;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (inst_valid !== 1'b0 || inst_o !== NOP || pc_o !== 32'h0) begin
         n_fail++; $display("FAIL arst_out: got valid=%b inst=%h pc=%h, expected 0 %h 0", inst_valid, inst_o, pc_o, NOP);
      end
      n_checks++;
      if (imem_req_valid !== 1'b0 || imem_addr !== 32'h0) begin
         n_fail++; $display("FAIL arst_req: got req=%b addr=%h, expected 0 0", imem_req_valid, imem_addr);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      mem_delay = 0;
      #1;
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
         n_fail++; $display("FAIL arst_restart: got req=%b addr=%h, expected 1 0", imem_req_valid, imem_addr);
      end
      @(negedge clk); #1;
      @(negedge clk); #1;
      n_checks++;
      if (inst_valid !== 1'b1 || pc_o !== 32'h0 || inst_o !== mem_word(32'h0)) begin
         n_fail++; $display("FAIL arst_inst: got valid=%b pc=%h inst=%h, expected 1 0 %h", inst_valid, pc_o, inst_o, mem_word(32'h0));
      end
   endtask

   task automatic test_wrap;
      logic [31:0] e;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp2_addr = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
      exp2_pc   = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if (d2_req_valid) begin
            n_checks++;
            e = (exp2_addr.size() > 0) ? exp2_addr.pop_front() : 32'hXXXX_XXXX;
            if (d2_addr !== e) begin n_fail++; $display("FAIL wrap_addr: got %h, expected %h", d2_addr, e); end
         end
         if (d2_inst_valid) begin
            n_checks++;
            e = (exp2_pc.size() > 0) ? exp2_pc.pop_front() : 32'hXXXX_XXXX;
            if (d2_pc !== e || d2_inst !== mem_word(e)) begin
               n_fail++; $display("FAIL wrap_pc: got pc=%h inst=%h, expected pc=%h", d2_pc, d2_inst, e);
            end
         end
      end
      n_checks++;
      if (exp2_addr.size() != 0 || exp2_pc.size() != 0) begin
         n_fail++; $display("FAIL wrap_count: got %0d requests and %0d outputs left over, expected 0 0", exp2_addr.size(), exp2_pc.size());
      end
   endtask

   initial begin
      n_checks       = 0;
      n_fail         = 0;
      mem_delay      = 0;
      rst            = 1'b0;
      inst_ready     = 1'b1;
      pc_src         = 1'b0;
      pc_target      = '0;
      imem_req_ready = 1'b1;
      #1;
      test_reset;
      test_first_fetch;
      test_stream;
      test_backpressure;
      test_redirect;
      test_redirect_rsp_same;
      test_reset_mid_wait;
      test_wrap;
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
